// File: rtl/postwrite.sv
// Two-entry posted-write buffer: a head register drives the sink, a skid register
// absorbs one extra word so full_o can be a registered flag with no path from full_i.
module postwrite #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         put_i,
  output logic         full_o,
  output logic [W-1:0] out,
  output logic         put_o,
  input  logic         full_i,
  output logic         overflow
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         full_q, full_d;
  logic         ovf_q, ovf_d;
  logic         accept;
  logic         drain;

  assign put_o    = (state_q != EMPTY) & ~full_i;
  assign drain    = put_o;
  assign accept   = put_i & ~full_q;
  assign full_o   = full_q;
  assign out      = head_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    ovf_d   = ovf_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          head_d = in;
        end else if (accept) begin
          skid_d  = in;
          state_d = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // A write while full is dropped; only the sticky flag records it.
        if (put_i) begin
          ovf_d = 1'b1;
        end
        if (drain) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    full_d = (state_d == TWO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_postwrite.sv
// Bench for postwrite: directed scenarios plus random traffic, all checked against a
// queue-based model of a two-word FIFO with a sticky overflow flag.
module tb_postwrite;

  logic       clock = 1'b0;
  logic       reset;
  logic       put_i;
  logic       full_i;
  logic       put_o;
  logic       full_o;
  logic       overflow;
  logic [7:0] in_d;
  logic [7:0] out_d;

  always #5 clock = ~clock;

  postwrite #(.W(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in_d),
    .put_i   (put_i),
    .full_o  (full_o),
    .out     (out_d),
    .put_o   (put_o),
    .full_i  (full_i),
    .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic       m_ovf;
  logic [7:0] m_head;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_head = 8'h00;
  endtask

  // Drive one clock of stimulus, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic p, input logic [7:0] d, input logic f);
    logic exp_put;
    logic was_full;
    put_i  = p;
    in_d   = d;
    full_i = f;
    #2;
    exp_put  = (mq.size() != 0) && !f;
    was_full = (mq.size() == 2);
    check("put_o", put_o, exp_put);
    check("out", out_d, (mq.size() != 0) ? mq[0] : m_head);
    check("full_o", full_o, was_full);
    check("overflow", overflow, m_ovf);
    @(posedge clock);
    if (exp_put) void'(mq.pop_front());
    if (p && was_full) m_ovf = 1'b1;
    else if (p) mq.push_back(d);
    if (mq.size() != 0) m_head = mq[0];
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] hello [5];
    logic       p;
    logic       f;
    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;
    reset  = 1'b1;
    put_i  = 1'b0;
    full_i = 1'b0;
    in_d   = 8'h00;
    model_reset();
    #1;
    check("rst_put_o", put_o, 1'b0);
    check("rst_full_o", full_o, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_out", out_d, 8'h00);
    // put_i is ignored while reset is held
    put_i = 1'b1;
    in_d  = 8'h5A;
    @(posedge clock);
    #1;
    check("rst_ignore_put", put_o, 1'b0);
    put_i = 1'b0;
    do_reset();

    // Single word, one-cycle latency, head retained once empty.
    cycle(1'b1, 8'h48, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Back-to-back stream at full rate.
    for (int i = 0; i < 5; i++) cycle(1'b1, hello[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Sink stalled: fill to TWO, hold, then drain.
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);

    // Write while full is dropped and latches overflow.
    cycle(1'b1, 8'h11, 1'b1);
    cycle(1'b1, 8'h22, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of a cycle while in TWO.
    cycle(1'b1, 8'h33, 1'b1);
    cycle(1'b1, 8'h44, 1'b1);
    put_i  = 1'b0;
    full_i = 1'b0;
    #1;
    check("pre_arst_full_o", full_o, 1'b1);
    check("pre_arst_overflow", overflow, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_full_o", full_o, 1'b0);
    check("arst_put_o", put_o, 1'b0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_out", out_d, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    // Accept must work on the first edge after release.
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Random traffic with producer obeying full.
    for (int i = 0; i < 1000; i++) begin
      f = ($urandom_range(0, 2) == 0);
      p = $urandom_range(0, 1) && (mq.size() != 2);
      cycle(p, 8'($urandom), f);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    check("drained_empty", put_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/postwrite.md
POSTWRITE -- requirements
Module: postwrite

Interface
REQ-001 Parameter W, default 8, data word width in bits.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in  input  W  producer write data, sampled on a rising edge with put_i=1.
REQ-005 put_i  input  1  producer write strobe; the producer asserts it only while full_o=0.
REQ-006 full_o  output  1  buffer cannot accept a word this cycle; registered output.
REQ-007 out  output  W  head-of-buffer word presented to the downstream sink.
REQ-008 put_o  output  1  write strobe to the downstream sink.
REQ-009 full_i  input  1  downstream sink cannot accept a word this cycle.
REQ-010 overflow  output  1  sticky flag: put_i was seen while full_o=1.

Function
REQ-011 The block SHALL be a two-entry posted-write buffer: the write-side counterpart of the pull-side prefetch stage.
REQ-012 The buffer SHALL be built from a head register (drives out) and a skid register.
REQ-013 The state machine SHALL have three states: EMPTY (0 words), ONE (head valid), TWO (head and skid valid).
REQ-014 put_o SHALL equal (state != EMPTY) & !full_i, combinationally.
REQ-015 A drain SHALL occur on any edge where put_o=1.
REQ-016 full_o SHALL be 1 exactly in state TWO, taken from a register; there SHALL be no combinational path from full_i or put_i to full_o.
REQ-017 An accept SHALL occur on any edge where put_i=1 and full_o=0.
REQ-018 EMPTY, accept: head<=in, go to ONE; put_o may assert in the next cycle (1-cycle latency).
REQ-019 ONE, accept and drain together: head<=in, stay in ONE.
REQ-020 ONE, accept without drain: skid<=in, go to TWO.
REQ-021 ONE, drain without accept: go to EMPTY.
REQ-022 TWO, drain: head<=skid, go to ONE; accepts are impossible in TWO.
REQ-023 TWO, put_i=1: the write SHALL be discarded, state and data unchanged, and overflow SHALL be set to 1.
REQ-024 Words SHALL leave in exactly the order they were accepted, with none lost or duplicated while overflow=0.
REQ-025 out SHALL hold the head word stable while full_i=1, and SHALL change only on a drain or on an accept into EMPTY/ONE.
REQ-026 In EMPTY, out SHALL retain the last head value; put_o=0 marks it invalid.
REQ-027 Sustained throughput SHALL be one word per clock when full_i stays 0.

Reset
REQ-028 reset=1 SHALL immediately force: state EMPTY, full_o=0, put_o=0, overflow=0, head=0, skid=0.
REQ-029 A reset asserted mid-operation SHALL discard all buffered words.
REQ-030 While reset=1, put_i SHALL be ignored.
REQ-031 On the first edge after reset release, an accept SHALL be possible.
REQ-032 overflow SHALL clear only through reset.

Verification
REQ-033 Reset, then write 8'h48 with full_i=0 -> out=8'h48 and put_o=1 on the next cycle; EMPTY after drain.
REQ-034 Stream 8'h48,8'h65,8'h6C,8'h6C,8'h6F, one per clock, with full_i=0 -> same sequence at the sink at one word per clock; full_o never 1.
REQ-035 full_i=1, write 8'h01 then 8'h02 -> full_o=1 after the second edge; hold 5 cycles -> out stays 8'h01; release -> sink gets 8'h01 then 8'h02, full_o drops after the first drain.
REQ-036 Force put_i=1 with data 8'hAA in TWO -> overflow=1 and stays 1; 8'hAA never appears on out.
REQ-037 Assert reset asynchronously between edges while in TWO -> full_o, put_o and overflow go to 0 before the next edge.
REQ-038 Random put_i (gated by full_o) and random full_i for 1000 cycles -> scoreboard shows an in-order, lossless match.
